// File: rtl/wb_line_ram_if.sv
`default_nettype none
// ============================================================================
// wb_line_ram_if : Wishbone B4 classic-cycle bundle for the line-wide bus
// Revision       : 1.0
// ============================================================================
interface wb_line_ram_if #(
   parameter int CACHE_WIDTH      = 128,
   parameter int ADDR_WIDTH       = 32,
   parameter int ADDR_GRANULARITY = 8
);
   logic [ADDR_WIDTH-1:0]                    wb_adr_i;
   logic [CACHE_WIDTH-1:0]                   wb_dat_i;
   logic [CACHE_WIDTH-1:0]                   wb_dat_o;
   logic                                     wb_we_i;
   logic [CACHE_WIDTH/ADDR_GRANULARITY-1:0]  wb_sel_i;
   logic                                     wb_stb_i;
   logic                                     wb_cyc_i;
   logic                                     wb_ack_o;
   logic                                     wb_err_o;
   logic                                     wb_rty_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
   );
endinterface
`default_nettype wire

// File: rtl/wb_line_ram.sv
`default_nettype none
// ============================================================================
// wb_line_ram : Wishbone B4 classic slave serving whole cache lines from RAM
// Revision    : 1.0
// ============================================================================
module wb_line_ram #(
   parameter int                    CACHE_WIDTH      = 128,
   parameter int                    ADDR_WIDTH       = 32,
   parameter int                    ADDR_GRANULARITY = 8,
   parameter int                    MEM_DEPTH        = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
   parameter int                    WAIT_STATES      = 2
) (
   input  wire logic    clk,
   input  wire logic    rst,
   wb_line_ram_if.slave wb
);
   localparam int         LINE_BYTES = CACHE_WIDTH / ADDR_GRANULARITY;
   localparam int         LD         = $clog2(LINE_BYTES);
   localparam int         LINES      = 1 << MEM_DEPTH;
   localparam bit         ZERO_WAIT  = (WAIT_STATES == 0);
   localparam logic [3:0] WAIT_CNT   = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  state_q;
   logic [3:0]              cnt_q;
   logic                    ack_q;
   logic                    err_q;
   logic [CACHE_WIDTH-1:0]  dat_q;
   logic                    we_q;
   logic                    bad_q;
   logic [LINE_BYTES-1:0]   sel_q;
   logic [MEM_DEPTH-1:0]    idx_q;
   logic [CACHE_WIDTH-1:0]  wdat_q;
   logic [CACHE_WIDTH-1:0]  mem_q [LINES];

   logic [ADDR_WIDTH-1:0]   off_d;
   logic                    mapped_d;
   logic                    aligned_d;
   logic                    bad_d;
   logic [MEM_DEPTH-1:0]    idx_d;
   logic                    req_d;
   logic                    live_d;
   logic                    commit_d;
   logic                    acc_we_d;
   logic                    acc_bad_d;
   logic [LINE_BYTES-1:0]   acc_sel_d;
   logic [MEM_DEPTH-1:0]    acc_idx_d;
   logic [CACHE_WIDTH-1:0]  acc_dat_d;

   assign off_d     = wb.wb_adr_i - BASE_ADDR;
   assign mapped_d  = (wb.wb_adr_i >= BASE_ADDR) && ((off_d >> (LD + MEM_DEPTH)) == '0);
   assign aligned_d = (wb.wb_adr_i[LD-1:0] == '0);
   assign bad_d     = ~mapped_d | ~aligned_d;
   assign idx_d     = off_d[LD +: MEM_DEPTH];
   assign req_d     = wb.wb_cyc_i & wb.wb_stb_i;

   // With no wait states the access commits on the accepting edge, so the
   // live bus values are used instead of the latched copies.
   assign live_d    = (state_q == S_IDLE);
   assign acc_we_d  = live_d ? wb.wb_we_i  : we_q;
   assign acc_bad_d = live_d ? bad_d       : bad_q;
   assign acc_sel_d = live_d ? wb.wb_sel_i : sel_q;
   assign acc_idx_d = live_d ? idx_d       : idx_q;
   assign acc_dat_d = live_d ? wb.wb_dat_i : wdat_q;

   assign commit_d  = ~rst & ((live_d & req_d & ZERO_WAIT) |
                              ((state_q == S_WAIT) & wb.wb_cyc_i & (cnt_q == 4'd1)));

   always_ff @(posedge clk) begin
      if (commit_d && acc_we_d && !acc_bad_d) begin
         for (int i = 0; i < LINE_BYTES; i++) begin
            if (acc_sel_d[i]) begin
               mem_q[acc_idx_d][i*ADDR_GRANULARITY +: ADDR_GRANULARITY] <=
                  acc_dat_d[i*ADDR_GRANULARITY +: ADDR_GRANULARITY];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         bad_q   <= 1'b0;
         sel_q   <= '0;
         idx_q   <= '0;
         wdat_q  <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
         case (state_q)
            S_IDLE: begin
               if (req_d) begin
                  we_q    <= wb.wb_we_i;
                  bad_q   <= bad_d;
                  sel_q   <= wb.wb_sel_i;
                  idx_q   <= idx_d;
                  wdat_q  <= wb.wb_dat_i;
                  cnt_q   <= WAIT_CNT;
                  state_q <= ZERO_WAIT ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (!wb.wb_cyc_i) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == 4'd1) begin
                  state_q <= S_RESP;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         if (commit_d) begin
            ack_q <= ~acc_bad_d;
            err_q <= acc_bad_d;
            dat_q <= (!acc_bad_d && !acc_we_d) ? mem_q[acc_idx_d] : '0;
         end
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wb_line_ram.sv
`default_nettype none
// ============================================================================
// tb_wb_line_ram : scoreboard bench, one slave with 2 wait states, one with 0
// Revision       : 1.0
// ============================================================================
module tb_wb_line_ram;
   localparam int     CW = 128, AW = 32, AG = 8, MD = 10, LB = CW / AG;
   localparam int     WS_A = 2, WS_B = 0;
   localparam longint BASE = 0;
   localparam longint SPAN = longint'(LB) << MD;

   typedef struct {
      bit            err;
      bit            chk;
      logic [CW-1:0] dat;
      int            due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   bit   mon_en = 1'b0;
   int   cyc_n = 0, checks = 0, errors = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   logic [7:0] mdl [bit [AW:0]];

   wb_line_ram_if #(.CACHE_WIDTH(CW), .ADDR_WIDTH(AW), .ADDR_GRANULARITY(AG)) if_a();
   wb_line_ram_if #(.CACHE_WIDTH(CW), .ADDR_WIDTH(AW), .ADDR_GRANULARITY(AG)) if_b();

   wb_line_ram #(.CACHE_WIDTH(CW), .ADDR_WIDTH(AW), .ADDR_GRANULARITY(AG), .MEM_DEPTH(MD),
                 .BASE_ADDR(AW'(BASE)), .WAIT_STATES(WS_A))
      u_a (.clk(clk), .rst(rst_a), .wb(if_a.slave));
   wb_line_ram #(.CACHE_WIDTH(CW), .ADDR_WIDTH(AW), .ADDR_GRANULARITY(AG), .MEM_DEPTH(MD),
                 .BASE_ADDR(AW'(BASE)), .WAIT_STATES(WS_B))
      u_b (.clk(clk), .rst(rst_b), .wb(if_b.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   // Reference model: byte-addressed memory, keyed by {instance, byte address}.
   function automatic bit is_bad(input logic [AW-1:0] adr);
      longint a = longint'(adr);
      return (a < BASE) || (a - BASE >= SPAN) || (a % LB != 0);
   endfunction

   function automatic bit known(input bit inst, input logic [AW-1:0] adr);
      for (int i = 0; i < LB; i++)
         if (!mdl.exists({inst, adr + AW'(i)})) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [CW-1:0] rd(input bit inst, input logic [AW-1:0] adr);
      logic [CW-1:0] v = '0;
      for (int i = 0; i < LB; i++)
         if (mdl.exists({inst, adr + AW'(i)})) v[i*8 +: 8] = mdl[{inst, adr + AW'(i)}];
      return v;
   endfunction

   task automatic predict(input bit inst, input bit we, input logic [AW-1:0] adr,
                          input logic [CW-1:0] dat, input logic [LB-1:0] sel, output exp_t e);
      e.err = is_bad(adr);
      e.chk = e.err;
      e.dat = '0;
      e.due = 0;
      if (!e.err) begin
         if (we) begin
            for (int i = 0; i < LB; i++)
               if (sel[i]) mdl[{inst, adr + AW'(i)}] = dat[i*8 +: 8];
         end else begin
            e.chk = known(inst, adr);
            e.dat = rd(inst, adr);
         end
      end
   endtask

   task automatic drive(input bit inst, input bit we, input logic [AW-1:0] adr,
                        input logic [CW-1:0] dat, input logic [LB-1:0] sel, input bit on);
      if (inst == 1'b0) begin
         if_a.wb_we_i = we; if_a.wb_adr_i = adr; if_a.wb_dat_i = dat; if_a.wb_sel_i = sel;
         if_a.wb_cyc_i = on; if_a.wb_stb_i = on;
      end else begin
         if_b.wb_we_i = we; if_b.wb_adr_i = adr; if_b.wb_dat_i = dat; if_b.wb_sel_i = sel;
         if_b.wb_cyc_i = on; if_b.wb_stb_i = on;
      end
   endtask

   // Slave A: master holds the request until a termination, then idles.
   task automatic req_a(input bit we, input logic [AW-1:0] adr, input logic [CW-1:0] dat,
                        input logic [LB-1:0] sel);
      exp_t e;
      bit   got = 1'b0;
      predict(1'b0, we, adr, dat, sel, e);
      e.due = cyc_n + WS_A + 1;
      q_a.push_back(e);
      drive(1'b0, we, adr, dat, sel, 1'b1);
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         got = if_a.wb_ack_o | if_a.wb_err_o;
      end
      chk("resp_seen_a", got, 1'b1);
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
      @(posedge clk); #1;
   endtask

   // Slave B: strobe never drops; each request is held for one accept and one ack cycle.
   task automatic op_b(input bit we, input logic [AW-1:0] adr, input logic [CW-1:0] dat,
                       input logic [LB-1:0] sel);
      exp_t e;
      predict(1'b1, we, adr, dat, sel, e);
      e.due = cyc_n + WS_B + 1;
      q_b.push_back(e);
      drive(1'b1, we, adr, dat, sel, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   function automatic logic [AW-1:0] rand_adr();
      int unsigned   k    = $urandom_range(0, 9);
      logic [AW-1:0] line = AW'($urandom_range(0, 15)) << 4;
      if (k < 7)       return line;
      else if (k == 7) return line | AW'($urandom_range(1, 15));
      else if (k == 8) return AW'(SPAN) + line;
      else             return 32'hFFFF_FFF0;
   endfunction

   function automatic logic [LB-1:0] rand_sel();
      int unsigned k = $urandom_range(0, 7);
      if (k == 0)      return '0;
      else if (k == 1) return '1;
      else             return LB'($urandom);
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         chk("ack_and_err_a", if_a.wb_ack_o & if_a.wb_err_o, 1'b0);
         chk("rty_a", if_a.wb_rty_o, 1'b0);
         if (if_a.wb_ack_o || if_a.wb_err_o) begin
            chk("resp_expected_a", q_a.size() != 0, 1'b1);
            if (q_a.size() != 0) begin
               ea = q_a.pop_front();
               chk("err_kind_a", if_a.wb_err_o, ea.err);
               chk("latency_a", cyc_n, ea.due);
               if (ea.chk) chk("data_a", if_a.wb_dat_o, ea.dat);
            end
         end else begin
            chk("idle_dat_a", if_a.wb_dat_o, '0);
         end
         chk("ack_and_err_b", if_b.wb_ack_o & if_b.wb_err_o, 1'b0);
         if (if_b.wb_ack_o || if_b.wb_err_o) begin
            chk("resp_expected_b", q_b.size() != 0, 1'b1);
            if (q_b.size() != 0) begin
               eb = q_b.pop_front();
               chk("err_kind_b", if_b.wb_err_o, eb.err);
               chk("latency_b", cyc_n, eb.due);
               if (eb.chk) chk("data_b", if_b.wb_dat_o, eb.dat);
            end
         end else begin
            chk("idle_dat_b", if_b.wb_dat_o, '0);
         end
      end
   end

   initial begin
      logic [CW-1:0] d;
      rst_a = 1'b1;
      rst_b = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
      drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack_a", if_a.wb_ack_o, 1'b0);
      chk("reset_err_a", if_a.wb_err_o, 1'b0);
      chk("reset_dat_a", if_a.wb_dat_o, '0);
      chk("reset_ack_b", if_b.wb_ack_o, 1'b0);
      chk("reset_err_b", if_b.wb_err_o, 1'b0);
      chk("reset_dat_b", if_b.wb_dat_o, '0);
      rst_a  = 1'b0;
      rst_b  = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      req_a(1'b1, 32'h10, 128'h0123456789ABCDEF0123456789ABCDEF, '1);
      req_a(1'b0, 32'h10, '0, '0);

      req_a(1'b1, 32'h20, '1, '1);
      req_a(1'b1, 32'h20, '0, 16'h00F0);
      req_a(1'b0, 32'h20, '0, '0);

      req_a(1'b0, 32'h14, '0, '0);
      req_a(1'b0, AW'(BASE + SPAN), '0, '0);
      req_a(1'b0, 32'h10, '0, '0);

      // Abandoned write: cyc drops during the first wait cycle.
      req_a(1'b1, 32'h30, {4{32'hA5A5_0030}}, '1);
      drive(1'b0, 1'b1, 32'h30, {4{32'h5A5A_FFFF}}, '1, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      req_a(1'b0, 32'h30, '0, '0);

      // Reset lands on the commit edge of a write.
      req_a(1'b1, 32'h40, {4{32'hC0DE_0040}}, '1);
      drive(1'b0, 1'b1, 32'h40, {4{32'hDEAD_BEEF}}, '1, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_a = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
      @(posedge clk); #1;
      chk("midrst_ack_a", if_a.wb_ack_o, 1'b0);
      chk("midrst_err_a", if_a.wb_err_o, 1'b0);
      rst_a = 1'b0;
      @(posedge clk); #1;
      req_a(1'b0, 32'h40, '0, '0);

      for (int l = 0; l < 16; l++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         req_a(1'b1, AW'(l) << 4, d, '1);
      end
      for (int n = 0; n < 60; n++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         req_a(1'($urandom_range(0, 1)), rand_adr(), d, rand_sel());
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      op_b(1'b1, 32'h00, {4{32'h0000_1111}}, '1);
      op_b(1'b1, 32'h10, {4{32'h2222_3333}}, '1);
      op_b(1'b0, 32'h00, '0, '0);
      op_b(1'b0, 32'h10, '0, '0);
      for (int l = 0; l < 16; l++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         op_b(1'b1, AW'(l) << 4, d, '1);
      end
      for (int n = 0; n < 40; n++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         op_b(1'($urandom_range(0, 1)), rand_adr(), d, rand_sel());
      end
      drive(1'b1, 1'b0, '0, '0, '0, 1'b0);

      repeat (10) @(posedge clk);
      #1;
      chk("drain_a", q_a.size(), 0);
      chk("drain_b", q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
